pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Each cycle it drives the writeEN/flush pair of every latch, including the ID/EX latch's writeEN and flush inputs. It resolves memory-wait freezes, load-use stalls, taken branch/jump flushes and the halt drain sequence. Sits in the datapath top level, fed by the cache hit signals and by ID/EX and EX-stage outputs.

Parameters:
LU_STALL, 1, bubble cycles inserted per detected load-use hazard (1..3)
DRAIN_CYCLES, 2, cycles after halt reaches MEM before halt asserts (1..7)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
ihit  input  1  instruction fetch complete this cycle
dhit  input  1  data access complete this cycle
mem_req  input  1  EX/MEM holds a load or store (dMemREN|dMemWEN)
ifid_rs  input  5  rs field of the instruction in IF/ID
ifid_rt  input  5  rt field of the instruction in IF/ID
idex_rt  input  5  rt_out of ID/EX
idex_dMemREN  input  1  dMemREN_out of ID/EX (load in EX)
ex_redirect  input  1  taken branch or jump (J/JAL/JR) resolved in EX
halt_mem  input  1  Halt flag present in EX/MEM
pc_WEN  output  1  PC register update enable
ifid_writeEN  output  1  IF/ID latch enable
ifid_flush  output  1  IF/ID load bubble
idex_writeEN  output  1  ID/EX latch enable
idex_flush  output  1  ID/EX load bubble
exmem_writeEN  output  1  EX/MEM latch enable
exmem_flush  output  1  EX/MEM load bubble
memwb_writeEN  output  1  MEM/WB latch enable
halt  output  1  sticky processor halted
state_dbg  output  3  current FSM state encoding

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Outputs are combinational from registered state, counter and current inputs. flush overrides writeEN inside a latch.
- While RST=1: all writeEN=0, all flush=1, pc_WEN=0, halt=0. Next state RUN, counter=0. A reset in any state, including mid-DRAIN or HALTED, returns the block to RUN.
- States: RUN, LU_STALL, DRAIN, HALTED.
- Priority each cycle, highest first:
  1. FREEZE: mem_req & !dhit. All writeEN=0, all flush=0, pc_WEN=0. State and counter hold. This applies in every state except HALTED.
  2. Redirect: ex_redirect. pc_WEN=1, ifid_flush=1, idex_flush=1, others advance. A pending load-use is cancelled: LU_STALL goes to RUN.
  3. Load-use (RUN only): idex_dMemREN & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
     - pc_WEN=0, ifid_writeEN=0, idex_flush=1, EX/MEM and MEM/WB advance.
     - If LU_STALL>1, go to LU_STALL with counter=LU_STALL-1; otherwise stay in RUN.
  4. I-miss: !ihit. pc_WEN=0, ifid_flush=1, downstream advances.
  5. Normal: pc_WEN=1, all writeEN=1, no flush.
- LU_STALL: same outputs as item 3. Counter decrements on each non-frozen cycle; at 0, go to RUN.
- halt_mem=1 (not frozen), from RUN or LU_STALL:
  - Go to DRAIN with counter=DRAIN_CYCLES. halt_mem takes precedence over redirect and load-use in the same cycle.
  - In DRAIN: pc_WEN=0; ifid_flush, idex_flush and exmem_flush asserted; memwb_writeEN=1.
  - Counter decrements on each non-frozen cycle; at 0, go to HALTED.
- HALTED: all writeEN=0, all flush=0, pc_WEN=0, halt=1. Held until RST; ihit, dhit and mem_req are ignored.
- Counter is 3 bits and cannot wrap: decrement only when nonzero.
- state_dbg encoding: RUN=0, LU_STALL=1, DRAIN=2, HALTED=3.

Decomposition:
- cpu_types_pkg gets typedef enum logic[2:0] hzstate_t {HZ_RUN, HZ_LU_STALL, HZ_DRAIN, HZ_HALTED}. regbits_t is reused for register fields.
- Optional sub-module hazard_detect: the combinational load-use comparator, producing lu_hazard.
- Latch controls are bundled as an interface-free port list. The top level wires them to the latch interfaces.

Test Plan:
- Reset: hold RST for 2 cycles -> all flush=1, writeEN=0, halt=0. First cycle after release with ihit=1, no hazards -> pc_WEN=1, all writeEN=1, state_dbg=0.
- Load-use: idex_dMemREN=1, idex_rt=5, ifid_rs=5, ihit=1.
  - Expect 1 cycle of pc_WEN=0, ifid_writeEN=0, idex_flush=1, then normal.
  - Repeat with idex_rt=0 -> no stall.
- Redirect beats load-use: ex_redirect=1 with the above hazard -> pc_WEN=1, ifid_flush=1, idex_flush=1, state stays RUN.
- FREEZE: mem_req=1, dhit=0 for 3 cycles during LU_STALL (LU_STALL=2) -> all enables 0 and counter held. Stall completes only after dhit=1.
- Halt: halt_mem=1 with DRAIN_CYCLES=2.
  - Expect 2 cycles in DRAIN with memwb_writeEN=1 and the three flushes asserted.
  - Then halt=1 stays sticky across 10 cycles with ihit toggling.
  - Assert RST -> back to RUN.
- I-miss: ihit=0 for 4 cycles -> pc_WEN=0, ifid_flush=1, idex_writeEN=1 each cycle. Normal operation resumes when ihit=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register field width, hazard sequencer states and
// the bundled latch control word with its canned per-situation values.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    HZ_RUN      = 3'd0,
    HZ_LU_STALL = 3'd1,
    HZ_DRAIN    = 3'd2,
    HZ_HALTED   = 3'd3
  } hzstate_t;

  typedef struct packed {
    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_flush;
    logic exmem_wen;
    logic exmem_flush;
    logic memwb_wen;
  } latch_ctrl_t;

  // Flushed latches keep writeEN=1 where they would otherwise advance; flush wins.
  localparam latch_ctrl_t CTRL_RESET    = 8'b0010_1010;
  localparam latch_ctrl_t CTRL_HOLD     = 8'b0000_0000;
  localparam latch_ctrl_t CTRL_DRAIN    = 8'b0010_1011;
  localparam latch_ctrl_t CTRL_REDIRECT = 8'b1111_1101;
  localparam latch_ctrl_t CTRL_LOADUSE  = 8'b0001_1101;
  localparam latch_ctrl_t CTRL_IMISS    = 8'b0111_0101;
  localparam latch_ctrl_t CTRL_NORMAL   = 8'b1101_0101;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dMemREN,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     lu_hazard
);

  // $zero is never a real dependency.
  assign lu_hazard = idex_dMemREN && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: memory freeze, load-use bubbles, redirect flush, halt drain.
//   state       | meaning
//   HZ_RUN      | normal issue, hazards checked every cycle
//   HZ_LU_STALL | extra load-use bubbles still owed (cnt_q of them)
//   HZ_DRAIN    | halt in MEM, flushing front end while older work retires
//   HZ_HALTED   | sticky halt until RST
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_STALL     = 1,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       mem_req,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic [4:0] idex_rt,
  input  logic       idex_dMemREN,
  input  logic       ex_redirect,
  input  logic       halt_mem,
  output logic       pc_WEN,
  output logic       ifid_writeEN,
  output logic       ifid_flush,
  output logic       idex_writeEN,
  output logic       idex_flush,
  output logic       exmem_writeEN,
  output logic       exmem_flush,
  output logic       memwb_writeEN,
  output logic       halt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] LU_INIT    = 3'(LU_STALL - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  hzstate_t    state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  latch_ctrl_t ctrl;
  logic        lu_hazard;
  logic        freeze;

  hazard_detect u_hazard_detect (
    .idex_dMemREN (idex_dMemREN),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .lu_hazard    (lu_hazard)
  );

  assign freeze = mem_req & ~dhit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_NORMAL;
    if (RST) begin
      ctrl    = CTRL_RESET;
      state_d = HZ_RUN;
      cnt_d   = '0;
    end else if (state_q == HZ_HALTED) begin
      ctrl = CTRL_HOLD;
    end else if (freeze) begin
      ctrl = CTRL_HOLD;
    end else if (state_q == HZ_DRAIN) begin
      ctrl = CTRL_DRAIN;
      if (cnt_q <= 3'd1) state_d = HZ_HALTED;
      if (cnt_q != '0)   cnt_d   = cnt_q - 3'd1;
    end else if (halt_mem) begin
      ctrl    = CTRL_DRAIN;
      state_d = HZ_DRAIN;
      cnt_d   = DRAIN_INIT;
    end else if (ex_redirect) begin
      ctrl    = CTRL_REDIRECT;
      state_d = HZ_RUN;
      cnt_d   = '0;
    end else if (state_q == HZ_LU_STALL) begin
      ctrl = CTRL_LOADUSE;
      if (cnt_q <= 3'd1) state_d = HZ_RUN;
      if (cnt_q != '0)   cnt_d   = cnt_q - 3'd1;
    end else if (lu_hazard) begin
      // The detecting cycle is itself the first bubble.
      ctrl = CTRL_LOADUSE;
      if (LU_STALL > 1) begin
        state_d = HZ_LU_STALL;
        cnt_d   = LU_INIT;
      end
    end else if (!ihit) begin
      ctrl = CTRL_IMISS;
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign pc_WEN        = ctrl.pc_wen;
  assign ifid_writeEN  = ctrl.ifid_wen;
  assign ifid_flush    = ctrl.ifid_flush;
  assign idex_writeEN  = ctrl.idex_wen;
  assign idex_flush    = ctrl.idex_flush;
  assign exmem_writeEN = ctrl.exmem_wen;
  assign exmem_flush   = ctrl.exmem_flush;
  assign memwb_writeEN = ctrl.memwb_wen;
  assign halt          = (state_q == HZ_HALTED) && !RST;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a counter-based reference model.
module tb_pipe_hazard_ctrl;

  localparam int LU_N    = 2;
  localparam int DRAIN_N = 2;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, mem_req, idex_dMemREN, ex_redirect, halt_mem;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       pc_WEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush;
  logic       exmem_writeEN, exmem_flush, memwb_writeEN, halt;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: remaining bubbles / drain cycles and a halted flag.
  bit m_halted;
  int m_drain;
  int m_stall;

  logic [11:0] obs, exp_v;

  pipe_hazard_ctrl #(.LU_STALL(LU_N), .DRAIN_CYCLES(DRAIN_N)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
    .idex_dMemREN(idex_dMemREN), .ex_redirect(ex_redirect), .halt_mem(halt_mem),
    .pc_WEN(pc_WEN), .ifid_writeEN(ifid_writeEN), .ifid_flush(ifid_flush),
    .idex_writeEN(idex_writeEN), .idex_flush(idex_flush),
    .exmem_writeEN(exmem_writeEN), .exmem_flush(exmem_flush),
    .memwb_writeEN(memwb_writeEN), .halt(halt), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  assign obs = {pc_WEN, ifid_writeEN, ifid_flush, idex_writeEN, idex_flush,
                exmem_writeEN, exmem_flush, memwb_writeEN, halt, state_dbg};

  function automatic bit m_luhaz();
    return idex_dMemREN && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  endfunction

  // {pc, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, exmem_fl, memwb_we, halt, state}
  function automatic logic [11:0] model_out();
    logic [2:0] st;
    st = m_halted ? 3'd3 : (m_drain > 0) ? 3'd2 : (m_stall > 0) ? 3'd1 : 3'd0;
    if (RST)                              return {8'b0010_1010, 1'b0, st};
    if (m_halted)                         return {8'b0000_0000, 1'b1, st};
    if (mem_req && !dhit)                 return {8'b0000_0000, 1'b0, st};
    if (m_drain > 0 || halt_mem)          return {8'b0010_1011, 1'b0, st};
    if (ex_redirect)                      return {8'b1111_1101, 1'b0, st};
    if (m_stall > 0 || m_luhaz())         return {8'b0001_1101, 1'b0, st};
    if (!ihit)                            return {8'b0111_0101, 1'b0, st};
    return {8'b1101_0101, 1'b0, st};
  endfunction

  function automatic void model_step();
    if (RST) begin
      m_halted = 0; m_drain = 0; m_stall = 0;
    end else if (m_halted || (mem_req && !dhit)) begin
      // nothing moves
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (halt_mem) begin
      m_drain = DRAIN_N; m_stall = 0;
    end else if (ex_redirect) begin
      m_stall = 0;
    end else if (m_stall > 0) begin
      m_stall--;
    end else if (m_luhaz()) begin
      m_stall = LU_N - 1;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    RST = 0; ihit = 1; dhit = 1; mem_req = 0; idex_dMemREN = 0;
    ex_redirect = 0; halt_mem = 0; ifid_rs = 0; ifid_rt = 0; idex_rt = 0;
  endtask

  task automatic test_reset();
    set_idle();
    RST = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) RST = 0;
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
    n_tests++;
    if (obs !== 12'b1101_0101_0000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs, 12'b1101_0101_0000);
    end
  endtask

  task automatic test_load_use();
    set_idle();
    idex_dMemREN = 1; idex_rt = 5; ifid_rs = 5;
    for (int c = 0; c < LU_N + 2; c++) begin
      if (c == LU_N) idex_dMemREN = 0;
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL load_use c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_lu_zero();
    set_idle();
    idex_dMemREN = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL lu_zero c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    set_idle();
    idex_dMemREN = 1; idex_rt = 7; ifid_rt = 7; ex_redirect = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin ex_redirect = 0; idex_dMemREN = 0; end
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL redirect c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_freeze();
    set_idle();
    idex_dMemREN = 1; idex_rt = 9; ifid_rs = 9;
    for (int c = 0; c < 8; c++) begin
      idex_dMemREN = (c == 0);
      mem_req = (c >= 1 && c <= 4);
      dhit    = (c == 4);
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL freeze c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    set_idle();
    halt_mem = 1;
    for (int c = 0; c < DRAIN_N + 14; c++) begin
      ihit    = c[0];
      mem_req = c[1];
      dhit    = c[2];
      RST     = (c == DRAIN_N + 12);
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL halt c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
      if (c == 0) halt_mem = 0;
    end
  endtask

  task automatic test_imiss();
    set_idle();
    for (int c = 0; c < 6; c++) begin
      ihit = (c >= 4);
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL imiss c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      RST          = ($urandom_range(0, 39) == 0);
      ihit         = ($urandom_range(0, 3) != 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      dhit         = $urandom_range(0, 1);
      idex_dMemREN = ($urandom_range(0, 2) == 0);
      idex_rt      = 5'($urandom_range(0, 3));
      ifid_rs      = 5'($urandom_range(0, 3));
      ifid_rt      = 5'($urandom_range(0, 3));
      ex_redirect  = ($urandom_range(0, 7) == 0);
      halt_mem     = ($urandom_range(0, 29) == 0);
      #1;
      exp_v = model_out();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random c%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    set_idle();
    RST = 1;
    @(posedge CLK);
    #1;
    m_halted = 0; m_drain = 0; m_stall = 0;
    test_reset();
    test_load_use();
    test_lu_zero();
    test_redirect();
    test_freeze();
    test_halt();
    test_imiss();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
